hbf_ctrl: RTL and testbench
===========================

Name: hbf_ctrl

Overview:
Sequencing and configuration controller placed in front of the half-band filter datapath (hbf).
- Accepts a serial sample stream through a valid/ready handshake and pairs consecutive samples into top (even) and bottom (odd) polyphase inputs. Issues a one-cycle input_valid per pair.
- Owns a shadow/active coefficient bank and drives the filter's coeff array from the active bank only.
- Guarantees coefficient swaps happen only after the filter pipeline has drained, so no output mixes old and new taps.

Parameters:
- INPUT_SAMPLE_DATA_WIDTH, 8, sample width.
- COEFF_DATA_WIDTH, 10, coefficient width.
- FILTER_ORDER, 15, number of coefficient slots.
- HBF_LATENCY, 6, cycles from filter input_valid to its valid_out.
- CNT_WIDTH, 16, output counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- s_valid  in  1  serial sample valid.
- s_ready  out  1  serial sample ready.
- s_data  in  INPUT_SAMPLE_DATA_WIDTH  serial sample.
- cfg_we  in  1  shadow coefficient write strobe.
- cfg_addr  in  4  shadow coefficient index.
- cfg_data  in  COEFF_DATA_WIDTH  coefficient value.
- cfg_commit  in  1  request shadow-to-active swap.
- input_valid  out  1  to filter: pair valid.
- input_sample_top  out  INPUT_SAMPLE_DATA_WIDTH  to filter: even sample.
- input_sample_bottom  out  INPUT_SAMPLE_DATA_WIDTH  to filter: odd sample.
- coeff  out  COEFF_DATA_WIDTH x [FILTER_ORDER-1:0] unpacked  to filter: active bank.
- hbf_valid_out  in  1  from filter: valid_out.
- coeff_valid  out  1  active bank has been loaded at least once.
- commit_pending  out  1  commit accepted, swap not yet done.
- state  out  2  IDLE=0, RUN=1, DRAIN=2, SWAP=3.
- out_count  out  CNT_WIDTH  number of filter outputs seen.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0. This includes shadow and active banks, phase, drain timer, state=IDLE and commit_pending=0.
- s_ready = 1 only in RUN. A transfer occurs on s_valid & s_ready.
- Phase 0 transfer: capture s_data into top hold register; phase becomes 1.
- Phase 1 transfer: register input_sample_top <= hold and input_sample_bottom <= s_data; input_valid=1 for exactly the next cycle; phase becomes 0.
  - input_valid is high for at most 1 of every 2 cycles.
  - Top and bottom outputs hold their values until the next pair.
- Shadow writes: cfg_we with cfg_addr < FILTER_ORDER writes shadow[cfg_addr], allowed in any state. Writes with cfg_addr >= FILTER_ORDER are ignored.
- Commit: cfg_commit sets commit_pending. If cfg_we and cfg_commit are asserted in the same cycle, the write is included in the swap.
- State transitions:
  - IDLE: commit_pending -> SWAP. Otherwise en & coeff_valid -> RUN. en with !coeff_valid stays in IDLE.
  - RUN: commit_pending or !en -> DRAIN. Load drain timer with HBF_LATENCY. Discard any half pair held in phase 1 and reset phase to 0.
  - DRAIN: s_ready=0; timer decrements each cycle. When the timer reaches 0: commit_pending -> SWAP; else en -> RUN; else -> IDLE.
  - SWAP: one cycle. Copy all shadow slots to active, set coeff_valid=1, clear commit_pending. Next state is RUN if en, else IDLE.
- A cfg_commit arriving during DRAIN or SWAP is held in commit_pending and honoured at the next exit point. A commit arriving in the SWAP cycle itself causes another drain/swap after returning to RUN.
- out_count increments by 1 on each hbf_valid_out, in any state, and wraps modulo 2^CNT_WIDTH.
- coeff changes only in the SWAP cycle.
- Reset mid-operation clears everything immediately. Any in-flight pair is lost.

Test Plan:
- Load shadow[0..14] = 1..15, commit in IDLE -> SWAP for 1 cycle, coeff[k] = k+1, coeff_valid=1, state back to IDLE.
- en=1, then stream samples 10,20,30,40 back-to-back -> input_valid pulses twice, 2 cycles apart, with (top,bottom) = (10,20) then (30,40).
- Stream 3 samples, then drop en -> sample 3 discarded, DRAIN held for 6 cycles with s_ready=0, then IDLE, phase=0.
- cfg_commit mid-RUN with new bank all 2 -> s_ready low, exactly 6 DRAIN cycles, then 1 SWAP cycle with coeff all 2, then RUN.
- cfg_we(addr=3, data=99) and cfg_commit in the same cycle -> coeff[3]=99 after swap. A write with cfg_addr=15 leaves all slots unchanged.
- Pulse hbf_valid_out 5 times -> out_count=5. Assert rst_n=0 mid-RUN -> out_count=0, coeff all 0, state=IDLE, coeff_valid=0.

Source files
------------

// File: rtl/hbf_ctrl_if.sv
// hbf_ctrl_if: sample-stream handshake plus filter-side bus of the half-band filter controller.
//   s_valid/s_ready/s_data         serial sample stream into the controller
//   input_valid/top/bottom         polyphase pair presented to the filter
//   coeff                          active coefficient bank presented to the filter
//   hbf_valid_out                  filter output strobe, counted by the controller
//   master: controller side, slave: source/filter side
interface hbf_ctrl_if #(
    parameter int INPUT_SAMPLE_DATA_WIDTH = 8,
    parameter int COEFF_DATA_WIDTH        = 10,
    parameter int FILTER_ORDER            = 15
);
    logic                               s_valid;
    logic                               s_ready;
    logic [INPUT_SAMPLE_DATA_WIDTH-1:0] s_data;
    logic                               input_valid;
    logic [INPUT_SAMPLE_DATA_WIDTH-1:0] input_sample_top;
    logic [INPUT_SAMPLE_DATA_WIDTH-1:0] input_sample_bottom;
    logic [COEFF_DATA_WIDTH-1:0]        coeff [FILTER_ORDER-1:0];
    logic                               hbf_valid_out;

    modport master (
        input  s_valid, s_data, hbf_valid_out,
        output s_ready, input_valid, input_sample_top, input_sample_bottom, coeff
    );

    modport slave (
        output s_valid, s_data, hbf_valid_out,
        input  s_ready, input_valid, input_sample_top, input_sample_bottom, coeff
    );
endinterface

// File: rtl/hbf_ctrl.sv
// hbf_ctrl: pairs a serial sample stream into polyphase inputs and swaps coefficient banks only after the filter drains.
//   clk, rst_n        clock, asynchronous active-low reset
//   en                run enable
//   cfg_we/addr/data  shadow coefficient write
//   cfg_commit        request shadow-to-active swap
//   bus               stream handshake and filter-side signals (hbf_ctrl_if.master)
//   coeff_valid       active bank has been loaded at least once
//   commit_pending    commit accepted, swap not yet done
//   state             IDLE=0, RUN=1, DRAIN=2, SWAP=3
//   out_count         filter outputs seen, wrapping
module hbf_ctrl #(
    parameter int INPUT_SAMPLE_DATA_WIDTH = 8,
    parameter int COEFF_DATA_WIDTH        = 10,
    parameter int FILTER_ORDER            = 15,
    parameter int HBF_LATENCY             = 6,
    parameter int CNT_WIDTH               = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        cfg_we,
    input  logic [3:0]                  cfg_addr,
    input  logic [COEFF_DATA_WIDTH-1:0] cfg_data,
    input  logic                        cfg_commit,
    hbf_ctrl_if.master                  bus,
    output logic                        coeff_valid,
    output logic                        commit_pending,
    output logic [1:0]                  state,
    output logic [CNT_WIDTH-1:0]        out_count
);
    localparam int TW = $clog2(HBF_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWAP} state_t;

    state_t                             st, st_nxt;
    logic                               phase;
    logic [INPUT_SAMPLE_DATA_WIDTH-1:0] hold;
    logic [TW-1:0]                      timer;
    logic [COEFF_DATA_WIDTH-1:0]        shadow [FILTER_ORDER-1:0];
    logic                               xfer;
    logic                               leave_run;

    assign bus.s_ready = st == RUN;
    assign xfer        = bus.s_valid & bus.s_ready;
    assign leave_run   = st == RUN && st_nxt == DRAIN;
    assign state       = st;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= IDLE;
        else        st <= st_nxt;

    // The DRAIN exit fires on the cycle the timer would reach zero, giving exactly HBF_LATENCY drain cycles.
    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    st_nxt = commit_pending ? SWAP : (en && coeff_valid) ? RUN : IDLE;
            RUN:     st_nxt = (commit_pending || !en) ? DRAIN : RUN;
            DRAIN:   st_nxt = timer != TW'(1) ? DRAIN : commit_pending ? SWAP : en ? RUN : IDLE;
            default: st_nxt = en ? RUN : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase                   <= 1'b0;
            hold                    <= '0;
            timer                   <= '0;
            shadow                  <= '{default: '0};
            bus.coeff               <= '{default: '0};
            bus.input_valid         <= 1'b0;
            bus.input_sample_top    <= '0;
            bus.input_sample_bottom <= '0;
            coeff_valid             <= 1'b0;
            commit_pending          <= 1'b0;
            out_count               <= '0;
        end else begin
            if (cfg_we && 32'(cfg_addr) < FILTER_ORDER) shadow[cfg_addr] <= cfg_data;
            if (st == SWAP) begin
                bus.coeff   <= shadow;
                coeff_valid <= 1'b1;
            end
            // A commit in the SWAP cycle itself survives the clear and triggers another swap.
            commit_pending <= cfg_commit | (commit_pending & (st != SWAP));
            timer          <= leave_run ? TW'(HBF_LATENCY) : (st == DRAIN) ? timer - 1'b1 : timer;
            if (xfer && !phase) hold <= bus.s_data;
            if (xfer && phase) begin
                bus.input_sample_top    <= hold;
                bus.input_sample_bottom <= bus.s_data;
            end
            bus.input_valid <= xfer & phase;
            // Leaving RUN drops any half pair sitting in the hold register.
            phase           <= leave_run ? 1'b0 : phase ^ xfer;
            out_count       <= out_count + CNT_WIDTH'(bus.hbf_valid_out);
        end
    end
endmodule

// File: tb/tb_hbf_ctrl.sv
// tb_hbf_ctrl: directed self-checking bench for hbf_ctrl.
module tb_hbf_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [9:0] cfg_data = '0;
    logic       cfg_commit = 1'b0;
    logic       coeff_valid;
    logic       commit_pending;
    logic [1:0] state;
    logic [15:0] out_count;
    int         tests = 0;
    int         fails = 0;
    int         n;

    hbf_ctrl_if bus ();

    hbf_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_commit     (cfg_commit),
        .bus            (bus.master),
        .coeff_valid    (coeff_valid),
        .commit_pending (commit_pending),
        .state          (state),
        .out_count      (out_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drain_len(output int cnt);
        cnt = 0;
        for (int i = 0; i < 20 && state == 2'd2; i++) begin
            if (bus.s_ready !== 1'b0) chk("drain_ready", 32'(bus.s_ready), 0);
            cnt++;
            step();
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.hbf_valid_out = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state), 0);
        chk("rst_cnt", 32'(out_count), 0);
        chk("rst_cv", 32'(coeff_valid), 0);
        chk("rst_pend", 32'(commit_pending), 0);
        chk("rst_ready", 32'(bus.s_ready), 0);
        chk("rst_iv", 32'(bus.input_valid), 0);
        chk("rst_coeff0", 32'(bus.coeff[0]), 0);
        rst_n = 1'b1;

        // initial bank load and commit from IDLE
        for (int k = 0; k < 15; k++) begin
            cfg_we = 1'b1; cfg_addr = 4'(k); cfg_data = 10'(k + 1);
            step();
        end
        cfg_we = 1'b0; cfg_commit = 1'b1;
        step();
        chk("c1_pend", 32'(commit_pending), 1);
        chk("c1_idle", 32'(state), 0);
        cfg_commit = 1'b0;
        step();
        chk("c1_swap", 32'(state), 3);
        chk("c1_coeff_old", 32'(bus.coeff[4]), 0);
        step();
        chk("c1_back_idle", 32'(state), 0);
        chk("c1_cv", 32'(coeff_valid), 1);
        chk("c1_pend_clr", 32'(commit_pending), 0);
        for (int k = 0; k < 15; k++) chk("c1_coeff", 32'(bus.coeff[k]), 32'(k + 1));

        // back-to-back pairing
        en = 1'b1;
        step();
        chk("run", 32'(state), 1);
        chk("run_ready", 32'(bus.s_ready), 1);
        bus.s_valid = 1'b1; bus.s_data = 8'd10; step();
        chk("p0_iv", 32'(bus.input_valid), 0);
        bus.s_data = 8'd20; step();
        chk("p1_iv", 32'(bus.input_valid), 1);
        chk("p1_top", 32'(bus.input_sample_top), 10);
        chk("p1_bot", 32'(bus.input_sample_bottom), 20);
        bus.s_data = 8'd30; step();
        chk("p2_iv", 32'(bus.input_valid), 0);
        chk("p2_top_hold", 32'(bus.input_sample_top), 10);
        bus.s_data = 8'd40; step();
        chk("p3_iv", 32'(bus.input_valid), 1);
        chk("p3_top", 32'(bus.input_sample_top), 30);
        chk("p3_bot", 32'(bus.input_sample_bottom), 40);

        // odd sample count, then drop en
        bus.s_data = 8'd50; step();
        bus.s_data = 8'd60; step();
        bus.s_data = 8'd70; step();
        bus.s_valid = 1'b0; en = 1'b0;
        step();
        chk("d_state", 32'(state), 2);
        chk("d_iv", 32'(bus.input_valid), 0);
        drain_len(n);
        chk("d_len", 32'(n), 6);
        chk("d_idle", 32'(state), 0);
        chk("d_top", 32'(bus.input_sample_top), 50);
        chk("d_bot", 32'(bus.input_sample_bottom), 60);
        en = 1'b1; step();
        bus.s_valid = 1'b1; bus.s_data = 8'd80; step();
        chk("ph0_iv", 32'(bus.input_valid), 0);
        bus.s_data = 8'd90; step();
        chk("ph_iv", 32'(bus.input_valid), 1);
        chk("ph_top", 32'(bus.input_sample_top), 80);
        chk("ph_bot", 32'(bus.input_sample_bottom), 90);
        bus.s_valid = 1'b0;

        // mid-RUN commit of bank all 2
        for (int k = 0; k < 15; k++) begin
            cfg_we = 1'b1; cfg_addr = 4'(k); cfg_data = 10'd2;
            step();
        end
        cfg_we = 1'b0; cfg_commit = 1'b1; step();
        chk("c2_pend", 32'(commit_pending), 1);
        chk("c2_run", 32'(state), 1);
        cfg_commit = 1'b0; step();
        chk("c2_drain", 32'(state), 2);
        chk("c2_ready", 32'(bus.s_ready), 0);
        drain_len(n);
        chk("c2_len", 32'(n), 6);
        chk("c2_swap", 32'(state), 3);
        chk("c2_coeff_old", 32'(bus.coeff[5]), 6);
        step();
        chk("c2_run_back", 32'(state), 1);
        chk("c2_pend_clr", 32'(commit_pending), 0);
        for (int k = 0; k < 15; k++) chk("c2_coeff", 32'(bus.coeff[k]), 2);

        // write and commit in the same cycle
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 10'd99; cfg_commit = 1'b1; step();
        cfg_we = 1'b0; cfg_commit = 1'b0; step();
        drain_len(n);
        chk("c3_swap", 32'(state), 3);
        step();
        chk("c3_coeff3", 32'(bus.coeff[3]), 99);
        chk("c3_coeff2", 32'(bus.coeff[2]), 2);

        // out-of-range write, plus a commit landing in the SWAP cycle
        cfg_we = 1'b1; cfg_addr = 4'd15; cfg_data = 10'd123; step();
        cfg_we = 1'b0; cfg_commit = 1'b1; step();
        cfg_commit = 1'b0; step();
        drain_len(n);
        chk("c4_swap", 32'(state), 3);
        cfg_commit = 1'b1; step();
        cfg_commit = 1'b0;
        chk("c4_run", 32'(state), 1);
        chk("c4_pend_again", 32'(commit_pending), 1);
        for (int k = 0; k < 15; k++) chk("c4_coeff", 32'(bus.coeff[k]), k == 3 ? 99 : 2);
        step();
        chk("c4_drain_again", 32'(state), 2);
        drain_len(n);
        chk("c4_len", 32'(n), 6);
        step();
        chk("c4_run_back", 32'(state), 1);
        chk("c4_pend_clr", 32'(commit_pending), 0);

        // output counting and async reset mid-RUN
        repeat (5) begin
            bus.hbf_valid_out = 1'b1; step();
            bus.hbf_valid_out = 1'b0; step();
        end
        chk("cnt5", 32'(out_count), 5);
        rst_n = 1'b0;
        #1;
        chk("ar_cnt", 32'(out_count), 0);
        chk("ar_state", 32'(state), 0);
        chk("ar_cv", 32'(coeff_valid), 0);
        for (int k = 0; k < 15; k++) chk("ar_coeff", 32'(bus.coeff[k]), 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("nocv_idle", 32'(state), 0);
        chk("nocv_ready", 32'(bus.s_ready), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
